f32_mult_ctrl: RTL and testbench
================================

# f32_mult_ctrl

Front-end sequencer for the `f32_mult` iterative FP32 multiplier.
- Accepts operand pairs on a valid/ready stream and screens IEEE-754 special cases (NaN, Inf, zero, subnormal, exponent over/underflow) that `f32_mult` does not handle; these are resolved locally.
- Holds operands stable, pulses `start` and waits for `done` for all other pairs, then presents the packed result with status flags on a valid/ready output stream.
- Sits between the operand source and the multiplier core, which it instantiates.

## Interface
- `TIMEOUT`, 16: max cycles in WAIT before abandoning the core result.
- `QNAN`, 32'h7FC0_0000: canonical quiet-NaN result.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset. Core receives `rst_n = ~rst`.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: controller can accept. High only in IDLE.
- `in_a`, `in_b` in 32: FP32 operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `out_p` out 32: FP32 product.
- `out_flags` out 4: {nv invalid, of overflow, uf underflow, to timeout}.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT. Reset state is IDLE.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `out_p`=0, `out_flags`=0, timeout counter 0, operand registers 0.
- IDLE: on `in_valid && in_ready`, register `in_a`/`in_b` and classify. Special case → OUT with the result below. Otherwise → ISSUE.
- Classification, first match wins. Sign s = a[31]^b[31]. Exp field 0 is treated as zero (subnormals flushed).
  - either operand NaN → QNAN, flags 0.
  - Inf × zero → QNAN, nv=1.
  - Inf × nonzero → {s,8'hFF,23'h0}.
  - zero × finite → {s,31'h0}.
  - es = ea+eb−127, computed signed in 10 bits:
    - es>254 → {s,8'hFF,0}, of=1.
    - es<1 → {s,31'h0}, uf=1.
    - otherwise issue to the core.
- ISSUE: drive core `start`=1 for exactly one cycle, clear counter, → WAIT.
- Core operands are the registered copies, stable from ISSUE until leaving WAIT.
- WAIT: counter increments each cycle.
  - On core `done`, capture `p`. If p[30:23]==8'hFF (es=254 carry), substitute {s,8'hFF,0} with of=1. → OUT.
  - If the counter reaches TIMEOUT without `done`, produce QNAN with to=1, → OUT.
- OUT: `out_valid`=1. `out_p`/`out_flags` are stable until `out_valid && out_ready`; then → IDLE.
- Core `start` is 0 in every state except ISSUE.

## Timing
- Accept at cycle T. Bypass result: `out_valid` at T+1.
- Issued result:
  - `start` at T+1; core `done` at T+5.
  - `out_valid` at T+6 (latency 6).
- Earliest next accept is the cycle after the output handshake. No overlap: throughput is 1 per 7 cycles with `out_ready` held high.
- `out_ready` low stalls in OUT indefinitely, with no change to outputs.
- `rst` asserted in any state, including mid-WAIT: next cycle IDLE, all outputs at reset values, core reset, in-flight result discarded.
- Late `done` after a timeout is ignored (controller is no longer in WAIT).

## Structure
- Package `f32_pkg`:
  - `QNAN` and `POS_INF` constants, bias constant 127.
  - field-extract functions for sign, exponent and mantissa.
  - `fp_class_t` enum {ZERO, NORM, INF, NAN}.
  - `ctrl_state_t`.
- Sub-module `f32_classify`: combinational operand classification and bypass-result/flag generation. The controller instantiates it and `f32_mult`.

## Test plan
- 0x40400000 × 0x40000000 (3×2) → `out_p`=0x40C00000, flags 0, `out_valid` 6 cycles after accept, single `start` pulse.
- 0x3FC00000 × 0x3FC00000 (1.5²) → 0x40100000 via the mantissa-overflow path.
- 0x7F800000 × 0x00000000 → 0x7FC00000, nv=1, `out_valid` at T+1, `start` never asserted.
- 0x7F000000 × 0x7F000000 → 0x7F800000, of=1. 0x00800000 × 0x00800000 → 0x00000000, uf=1. 0xBF800000 × 0x00000000 → 0x80000000.
- Hold `out_ready`=0 for 5 cycles after `out_valid` → `out_p`/flags stable, `in_ready`=0; release → handshake, `in_ready`=1 next cycle.
- Assert `rst` 2 cycles into WAIT → outputs at reset next cycle and no stale result. Separately, force core `done` low → QNAN with to=1 after TIMEOUT cycles.

Source files
------------

// File: rtl/f32_pkg.sv
// Shared FP32 types, constants and field helpers for the multiplier front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package f32_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam int          BIAS    = 127;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} ctrl_state_t;

    // Bit order matches out_flags: {nv, of, uf, to}.
    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic to;
    } flags_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] x);
        return x[22:0];
    endfunction

    // Exponent field 0 is reported as ZERO, so subnormals are flushed.
    function automatic fp_class_t fp_class(input logic [31:0] x);
        if (fp_exp(x) == 8'hFF) begin
            return (fp_man(x) != 23'd0) ? NAN : INF;
        end else if (fp_exp(x) == 8'h00) begin
            return ZERO;
        end else begin
            return NORM;
        end
    endfunction

endpackage

// File: rtl/f32_classify.sv
// Screens an FP32 operand pair for cases the iterative core cannot handle.
// Latency: combinational.
// Backpressure: none; outputs follow a/b.
// Ports: a, b operands; bypass=1 when res/flags are final and the core is not needed.
module f32_classify
    import f32_pkg::*;
#(
    parameter logic [31:0] NAN_RES = QNAN
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        bypass,
    output logic [31:0] res,
    output flags_t      flags
);

    fp_class_t          ca;
    fp_class_t          cb;
    logic               s;
    logic signed [9:0]  es;

    always_comb begin
        ca     = fp_class(a);
        cb     = fp_class(b);
        s      = fp_sign(a) ^ fp_sign(b);
        es     = $signed({2'b00, fp_exp(a)}) + $signed({2'b00, fp_exp(b)})
               - $signed(10'(BIAS));
        bypass = 1'b1;
        res    = 32'h0;
        flags  = '0;
        // Priority order matters: NaN beats Inf*0, which beats plain Inf.
        if (ca == NAN || cb == NAN) begin
            res = NAN_RES;
        end else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
            res      = NAN_RES;
            flags.nv = 1'b1;
        end else if (ca == INF || cb == INF) begin
            res = {s, POS_INF[30:0]};
        end else if (ca == ZERO || cb == ZERO) begin
            res = {s, 31'h0};
        end else if (es > 10'sd254) begin
            res      = {s, POS_INF[30:0]};
            flags.of = 1'b1;
        end else if (es < 10'sd1) begin
            res      = {s, 31'h0};
            flags.uf = 1'b1;
        end else begin
            bypass = 1'b0;
        end
    end

endmodule

// File: rtl/f32_mult.sv
// Iterative FP32 multiplier core for normal operands with in-range exponent.
// Latency: done pulses 4 cycles after start; p valid while done is high.
// Backpressure: none; start while busy is ignored.
// Ports: clk, rst_n (sync, active-low), start, a, b, done, p (truncated product).
module f32_mult
    import f32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] p
);

    logic [23:0] ma_q;
    logic [23:0] mb_q;
    logic [47:0] acc_q;
    logic [7:0]  exp_q;
    logic        sign_q;
    logic [1:0]  step_q;
    logic        busy_q;
    logic [5:0]  shamt;
    logic [47:0] pp;
    logic        norm;
    logic [7:0]  exp_out;

    // Multiplier consumed 6 bits per cycle; step 0 is folded into the start cycle.
    assign shamt = {2'b00, step_q, 2'b00} + {3'b000, step_q, 1'b0};
    assign pp    = ({24'b0, ma_q} * {42'b0, mb_q[shamt +: 6]}) << shamt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ma_q   <= '0;
            mb_q   <= '0;
            acc_q  <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            step_q <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy_q) begin
                ma_q   <= {1'b1, a[22:0]};
                mb_q   <= {1'b1, b[22:0]};
                acc_q  <= {24'b0, 1'b1, a[22:0]} * {42'b0, b[5:0]};
                // Caller guarantees the biased sum lands in 1..254, so 8-bit wrap is safe.
                exp_q  <= a[30:23] + b[30:23] - 8'(BIAS);
                sign_q <= a[31] ^ b[31];
                step_q <= 2'd1;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                acc_q  <= acc_q + pp;
                step_q <= step_q + 2'd1;
                if (step_q == 2'd3) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign norm    = acc_q[47];
    assign exp_out = exp_q + {7'b0, norm};
    assign p       = {sign_q, exp_out, norm ? acc_q[46:24] : acc_q[45:23]};

endmodule

// File: rtl/f32_mult_ctrl.sv
// Operand sequencer: screens special cases locally, otherwise runs f32_mult.
// Latency: 1 cycle for bypassed pairs, 6 cycles for pairs sent to the core.
// Backpressure: one pair in flight; in_ready only in IDLE, OUT holds until out_ready.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_a/in_b,
//        out_valid/out_ready/out_p/out_flags {nv, of, uf, to}.
module f32_mult_ctrl #(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] QNAN    = f32_pkg::QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic [3:0]  out_flags
);

    import f32_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    ctrl_state_t       state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       p_q, p_d;
    flags_t            flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s;

    logic              cls_bypass;
    logic [31:0]       cls_res;
    flags_t            cls_flags;
    logic              core_start;
    logic              core_done;
    logic [31:0]       core_p;

    // Classify the live inputs so a bypassed result is ready the cycle after accept.
    f32_classify #(.NAN_RES(QNAN)) u_classify (
        .a      (in_a),
        .b      (in_b),
        .bypass (cls_bypass),
        .res    (cls_res),
        .flags  (cls_flags)
    );

    f32_mult u_core (
        .clk   (clk),
        .rst_n (~rst),
        .start (core_start),
        .a     (a_q),
        .b     (b_q),
        .done  (core_done),
        .p     (core_p)
    );

    assign s = a_q[31] ^ b_q[31];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        core_start = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    if (cls_bypass) begin
                        p_d     = cls_res;
                        flags_d = cls_flags;
                        state_d = OUT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (core_done) begin
                    flags_d = '0;
                    // Mantissa carry at the top exponent rolls the core into the Inf/NaN encoding.
                    if (core_p[30:23] == 8'hFF) begin
                        p_d        = {s, POS_INF[30:0]};
                        flags_d.of = 1'b1;
                    end else begin
                        p_d = core_p;
                    end
                    state_d = OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    p_d        = QNAN;
                    flags_d    = '0;
                    flags_d.to = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_p     = p_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_f32_mult_ctrl.sv
// Self-checking bench for f32_mult_ctrl with an expected-result queue.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_f32_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic [3:0]  out_flags;

    always #5 clk = ~clk;

    f32_mult_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_flags (out_flags)
    );

    typedef struct {
        logic [31:0] p;
        logic [3:0]  f;
        int          lat;
        int          st;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [3:0]  f;
        int          lat;
        int          st;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair and returns in the cycle after the accept handshake.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        output int t_acc, output bit ok);
        int w = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        ok    = in_ready;
        t_acc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for out_valid (bounded), reporting latency from accept and start pulses seen.
    task automatic collect(output logic [31:0] p, output logic [3:0] f,
                           output int lat, output int starts, output bit ok);
        lat    = 1;
        starts = 0;
        ok     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            starts += int'(dut.core_start);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        p = out_p;
        f = out_flags;
        if (ok && out_ready) tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
        end
        n_tests++;
        if (out_p !== 32'h0 || out_flags !== 4'h0 || dut.core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: p=%h flags=%b start=%b, need 0/0/0",
                     out_p, out_flags, dut.core_start);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic run_table(input string name, input vec_t v[$]);
        logic [31:0] p;
        logic [3:0]  f;
        int          lat, st, t_acc;
        bit          ok_in, ok;
        exp_t        e;
        foreach (v[i]) begin
            sb.push_back('{v[i].p, v[i].f, v[i].lat, v[i].st});
            send(v[i].a, v[i].b, t_acc, ok_in);
            collect(p, f, lat, st, ok);
            e = sb.pop_front();
            n_tests++;
            if (!ok_in || !ok || p !== e.p || f !== e.f) begin
                n_fail++;
                $display("FAIL %s_result[%0d] %h*%h: p=%h flags=%b, need p=%h flags=%b",
                         name, i, v[i].a, v[i].b, p, f, e.p, e.f);
            end
            n_tests++;
            if (lat !== e.lat || st !== e.st) begin
                n_fail++;
                $display("FAIL %s_timing[%0d]: latency=%0d starts=%0d, need %0d/%0d",
                         name, i, lat, st, e.lat, e.st);
            end
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_return[%0d]: in_ready=%b out_valid=%b, need 1/0",
                         name, i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_issue();
        vec_t v[$];
        v.push_back('{32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, 6, 1});
        v.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 6, 1});
        v.push_back('{32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000, 6, 1});
        v.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 6, 1});
        v.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 6, 1});
        v.push_back('{32'h7F400000, 32'h3FC00000, 32'h7F800000, 4'b0100, 6, 1});
        run_table("issue", v);
    endtask

    task automatic test_bypass();
        vec_t v[$];
        v.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, 0});
        v.push_back('{32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1, 0});
        v.push_back('{32'h7F800001, 32'h00000000, 32'h7FC00000, 4'b0000, 1, 0});
        v.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 1, 0});
        v.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1, 0});
        v.push_back('{32'hBF800000, 32'h00000000, 32'h80000000, 4'b0000, 1, 0});
        v.push_back('{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, 1, 0});
        v.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, 1, 0});
        v.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100, 1, 0});
        v.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 4'b0010, 1, 0});
        v.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0010, 1, 0});
        run_table("bypass", v);
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        logic [3:0]  f;
        int          lat, st, t0, t1;
        bit          ok_in, ok;
        exp_t        e;
        sb.push_back('{32'h40C00000, 4'b0000, 6, 1});
        send(32'h40400000, 32'h40000000, t0, ok_in);
        collect(p, f, lat, st, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || p !== e.p || f !== e.f) begin
            n_fail++;
            $display("FAIL b2b_first: p=%h flags=%b, need %h/%b", p, f, e.p, e.f);
        end
        sb.push_back('{32'h40800000, 4'b0000, 6, 1});
        send(32'h40000000, 32'h40000000, t1, ok_in);
        collect(p, f, lat, st, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || p !== e.p || f !== e.f) begin
            n_fail++;
            $display("FAIL b2b_second: p=%h flags=%b, need %h/%b", p, f, e.p, e.f);
        end
        n_tests++;
        if (t1 - t0 !== 7) begin
            n_fail++;
            $display("FAIL b2b_spacing: accepts %0d cycles apart, need 7", t1 - t0);
        end
    endtask

    task automatic test_stall();
        int   t_acc;
        bit   ok_in;
        int   w = 0;
        exp_t e;
        sb.push_back('{32'h40C00000, 4'b0000, 6, 1});
        out_ready = 1'b0;
        send(32'h40400000, 32'h40000000, t_acc, ok_in);
        while (!out_valid && w < 40) begin
            tick();
            w++;
        end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_p !== e.p || out_flags !== e.f) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b in_ready=%b p=%h flags=%b, need 1/0/%h/%b",
                         i, out_valid, in_ready, out_p, out_flags, e.p, e.f);
            end
            tick();
        end
        out_ready = 1'b1;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_pre_release: valid=%b in_ready=%b, need 1/0", out_valid, in_ready);
        end
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: in_ready=%b valid=%b, need 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int t_acc;
        bit ok_in;
        int seen = 0;
        send(32'h40400000, 32'h40000000, t_acc, ok_in);
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== 32'h0 ||
            out_flags !== 4'h0 || dut.cnt_q !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: valid=%b in_ready=%b p=%h flags=%b cnt=%0d, need 0/1/0/0/0",
                     out_valid, in_ready, out_p, out_flags, dut.cnt_q);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_stale: out_valid seen %0d cycles, need 0", seen);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] p;
        logic [3:0]  f;
        int          lat, st, t_acc;
        bit          ok_in, ok;
        exp_t        e;
        sb.push_back('{32'h7FC00000, 4'b0001, 18, 1});
        force dut.core_done = 1'b0;
        send(32'h40400000, 32'h40000000, t_acc, ok_in);
        collect(p, f, lat, st, ok);
        release dut.core_done;
        e = sb.pop_front();
        n_tests++;
        if (!ok || p !== e.p || f !== e.f) begin
            n_fail++;
            $display("FAIL timeout_result: p=%h flags=%b, need %h/%b", p, f, e.p, e.f);
        end
        n_tests++;
        if (lat !== e.lat || st !== e.st) begin
            n_fail++;
            $display("FAIL timeout_timing: latency=%0d starts=%0d, need %0d/%0d",
                     lat, st, e.lat, e.st);
        end
        sb.push_back('{32'h40100000, 4'b0000, 6, 1});
        send(32'h3FC00000, 32'h3FC00000, t_acc, ok_in);
        collect(p, f, lat, st, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || p !== e.p || f !== e.f || lat !== e.lat) begin
            n_fail++;
            $display("FAIL timeout_recover: p=%h flags=%b lat=%0d, need %h/%b/%0d",
                     p, f, lat, e.p, e.f, e.lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_issue();
        test_bypass();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_timeout();
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
